// File: rtl/dft_frame_sched.sv
// dft_frame_sched: arbitrates two streaming requesters onto a single DFT core sink.
// A frame starts on a requester's sop beat and carries its length and direction.
// Frames are forwarded with zero latency, and a fixed idle gap follows every frame.
// Frames with an illegal length and stray non-sop samples are discarded and counted.
// A small tag FIFO remembers which requester owns each frame still inside the core.
//
// Ports:
//   clk, rst_n                              clock, asynchronous active-low reset
//   req_valid/ready/sop [1:0]               per-requester stream handshake
//   req_real/imag [35:0]                    {req1, req0} 18-bit samples
//   req_dftpts [23:0]                       {req1, req0} 12-bit frame lengths
//   req_inverse [1:0]                       per-requester inverse flag
//   dft_valid/ready/sop/eop                 core sink handshake
//   dft_real/imag, dft_pts, dft_inverse     core sink data and configuration
//   src_valid, src_sop                      core source start-of-frame (pops the tag FIFO)
//   out_chan, out_chan_valid                owner of the current output frame
//   clr_err, cfg_err                        sticky illegal-length flag and its clear
//   busy, drop_cnt                          FSM not idle; saturating discard count
module dft_frame_sched #(
    parameter logic [11:0] MAX_PTS   = 12'd1200,
    parameter int          GAP_CYC   = 4,
    parameter int          TAG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_sop,
    input  logic [35:0] req_real,
    input  logic [35:0] req_imag,
    input  logic [23:0] req_dftpts,
    input  logic [1:0]  req_inverse,
    output logic        dft_valid,
    input  logic        dft_ready,
    output logic        dft_sop,
    output logic        dft_eop,
    output logic [17:0] dft_real,
    output logic [17:0] dft_imag,
    output logic [11:0] dft_pts,
    output logic        dft_inverse,
    input  logic        src_valid,
    input  logic        src_sop,
    output logic        out_chan,
    output logic        out_chan_valid,
    input  logic        clr_err,
    output logic        busy,
    output logic        cfg_err,
    output logic [15:0] drop_cnt
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(TAG_DEPTH - 1);
    localparam logic [CW-1:0] OCC_FULL  = CW'(TAG_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_r;
    logic            ptr_r;      // lane preferred when both lanes request together
    logic            chan_r;
    logic            inv_r;
    logic [11:0]     pts_r;
    logic [11:0]     cnt_r;
    logic [GW-1:0]   gap_r;
    logic            tag_mem_r [TAG_DEPTH];
    logic [AW-1:0]   wr_r;
    logic [AW-1:0]   rd_r;
    logic [CW-1:0]   occ_r;
    logic            cfg_err_r;
    logic [15:0]     drop_r;

    logic [1:0]      legal_s;
    logic [1:0]      legal_cand_s;
    logic [1:0]      idle_discard_s;
    logic [1:0]      req_ready_s;
    logic            grant_s;
    logic            grant_lane_s;
    logic [1:0]      drop_inc_s;
    logic            err_set_s;
    logic            dft_valid_s;
    logic            beat_s;
    logic            last_beat_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            pop_s;
    logic [16:0]     drop_sum_s;

    assign legal_s[0] = (req_dftpts[11:0]  != 12'd0) && (req_dftpts[11:0]  <= MAX_PTS);
    assign legal_s[1] = (req_dftpts[23:12] != 12'd0) && (req_dftpts[23:12] <= MAX_PTS);
    assign legal_cand_s   = req_valid & req_sop & legal_s;
    // Stray non-sop samples and sop samples with an illegal length are both swallowed in IDLE.
    assign idle_discard_s = req_valid & (~req_sop | ~legal_s);
    assign fifo_full_s    = (occ_r == OCC_FULL);
    assign fifo_empty_s   = (occ_r == CW'(0));
    assign pop_s          = src_valid & src_sop & ~fifo_empty_s;
    assign last_beat_s    = beat_s & (cnt_r == (pts_r - 12'd1));
    assign drop_sum_s     = {1'b0, drop_r} + {15'd0, drop_inc_s};

    // Handshake, grant and discard decisions for the current state.
    always_comb begin
        req_ready_s  = 2'b00;
        grant_s      = 1'b0;
        grant_lane_s = 1'b0;
        drop_inc_s   = 2'b00;
        err_set_s    = 1'b0;
        dft_valid_s  = 1'b0;
        beat_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = idle_discard_s;
                drop_inc_s  = {1'b0, idle_discard_s[0]} + {1'b0, idle_discard_s[1]};
                err_set_s   = |(req_valid & req_sop & ~legal_s);
                // The granted sop beat is left on the lane so the XFER state forwards it.
                if ((legal_cand_s != 2'b00) && !fifo_full_s) begin
                    grant_s      = 1'b1;
                    grant_lane_s = (legal_cand_s == 2'b11) ? ptr_r : legal_cand_s[1];
                end else begin
                    grant_s      = 1'b0;
                end
            end
            ST_XFER: begin
                dft_valid_s         = chan_r ? req_valid[1] : req_valid[0];
                beat_s              = dft_valid_s & dft_ready;
                req_ready_s[chan_r] = dft_ready;
            end
            ST_GAP: begin
                req_ready_s = 2'b00;
            end
            default: begin
                req_ready_s = 2'b00;
            end
        endcase
    end

    // Zero-latency data path to the core; everything is held at zero outside XFER.
    always_comb begin
        if (state_r == ST_XFER) begin
            dft_real    = chan_r ? req_real[35:18] : req_real[17:0];
            dft_imag    = chan_r ? req_imag[35:18] : req_imag[17:0];
            dft_pts     = pts_r;
            dft_inverse = inv_r;
            dft_sop     = (cnt_r == 12'd0);
            dft_eop     = (cnt_r == (pts_r - 12'd1));
        end else begin
            dft_real    = 18'd0;
            dft_imag    = 18'd0;
            dft_pts     = 12'd0;
            dft_inverse = 1'b0;
            dft_sop     = 1'b0;
            dft_eop     = 1'b0;
        end
    end

    // Ready is masked while reset is asserted because IDLE would otherwise accept stray samples.
    assign req_ready      = req_ready_s & {2{rst_n}};
    assign dft_valid      = dft_valid_s;
    assign busy           = (state_r != ST_IDLE);
    assign cfg_err        = cfg_err_r;
    assign drop_cnt       = drop_r;
    assign out_chan_valid = ~fifo_empty_s;
    assign out_chan       = fifo_empty_s ? 1'b0 : tag_mem_r[rd_r];

    // Frame FSM: grant, beat counting, and the fixed inter-frame gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= 1'b0;
            chan_r  <= 1'b0;
            inv_r   <= 1'b0;
            pts_r   <= 12'd0;
            cnt_r   <= 12'd0;
            gap_r   <= GW'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_r <= ST_XFER;
                        chan_r  <= grant_lane_s;
                        pts_r   <= grant_lane_s ? req_dftpts[23:12] : req_dftpts[11:0];
                        inv_r   <= req_inverse[grant_lane_s];
                        cnt_r   <= 12'd0;
                    end
                end
                ST_XFER: begin
                    if (last_beat_s) begin
                        state_r <= ST_GAP;
                        gap_r   <= GW'(0);
                        cnt_r   <= 12'd0;
                        // Next tie goes to the other lane.
                        ptr_r   <= ~chan_r;
                    end else if (beat_s) begin
                        cnt_r   <= cnt_r + 12'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_r == GAP_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_r   <= gap_r + GW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Channel tag FIFO: push on grant, pop on each core output sop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_r[i] <= 1'b0;
            end
            wr_r  <= AW'(0);
            rd_r  <= AW'(0);
            occ_r <= CW'(0);
        end else begin
            if (grant_s) begin
                tag_mem_r[wr_r] <= grant_lane_s;
                wr_r <= (wr_r == ADDR_LAST) ? AW'(0) : wr_r + AW'(1);
            end
            if (pop_s) begin
                rd_r <= (rd_r == ADDR_LAST) ? AW'(0) : rd_r + AW'(1);
            end
            case ({grant_s, pop_s})
                2'b10:   occ_r <= occ_r + CW'(1);
                2'b01:   occ_r <= occ_r - CW'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Sticky error flag (set wins over clear) and saturating discard counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_r <= 1'b0;
            drop_r    <= 16'd0;
        end else begin
            if (err_set_s) begin
                cfg_err_r <= 1'b1;
            end else if (clr_err) begin
                cfg_err_r <= 1'b0;
            end
            drop_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
        end
    end

endmodule
